// File: rtl/channel_input_buffer_pkg.sv
// Shared interconnect/link definitions: word and tag widths, the link packet,
// and the default channel buffer depth used for PE-level instantiation.
package channel_input_buffer_pkg;

  localparam int TIA_TAG_WIDTH            = 2;
  localparam int TIA_WORD_WIDTH           = 32;
  localparam int TIA_CHANNEL_BUFFER_DEPTH = 4;
  localparam int TIA_NUM_PHYSICAL_PLANES  = 4;

  typedef struct packed {
    logic [TIA_TAG_WIDTH-1:0]  tag;
    logic [TIA_WORD_WIDTH-1:0] data;
  } packet_t;

endpackage

// File: rtl/link_if.sv
// Local link between the interconnect receiver adapter and a PE channel:
// req/packet flow downstream, ack flows back upstream.
interface link_if;
  import channel_input_buffer_pkg::*;

  logic    req;
  logic    ack;
  packet_t packet;

  modport sender   (output req, output packet, input ack);
  modport receiver (input req, input packet, output ack);

endinterface

// File: rtl/channel_input_buffer.sv
// Per-plane receive FIFO: accepts link packets via req/ack and presents the
// head entry to the PE, which pops it with a single-cycle dequeue strobe.
module channel_input_buffer
  import channel_input_buffer_pkg::*;
#(
  parameter  int DEPTH       = TIA_CHANNEL_BUFFER_DEPTH,
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  link_if.receiver                  input_link,
  input  logic                      dequeue,
  output logic                      head_valid,
  output logic [TIA_TAG_WIDTH-1:0]  head_tag,
  output logic [TIA_WORD_WIDTH-1:0] head_data,
  output logic [COUNT_WIDTH-1:0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [PTR_WIDTH-1:0]   PTR_LAST   = PTR_WIDTH'(DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_FULL = COUNT_WIDTH'(DEPTH);

  packet_t                mem [DEPTH];
  logic [PTR_WIDTH-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PTR_WIDTH-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [COUNT_WIDTH-1:0] count_reg, count_next;
  logic                   enq;
  logic                   deq;

  // Status is decoded from the registered count only, so ack never depends
  // combinationally on req or dequeue.
  assign full       = (count_reg == COUNT_FULL);
  assign empty      = (count_reg == '0);
  assign head_valid = !empty;
  assign count      = count_reg;

  assign input_link.ack = reset && !full;

  assign enq = input_link.req && input_link.ack;
  assign deq = dequeue && head_valid;

  assign head_tag  = mem[rd_ptr_reg].tag;
  assign head_data = mem[rd_ptr_reg].data;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (enq) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_WIDTH'(1);
    end
    if (deq) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_WIDTH'(1);
    end
    case ({enq, deq})
      2'b10:   count_next = count_reg + COUNT_WIDTH'(1);
      2'b01:   count_next = count_reg - COUNT_WIDTH'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (enq) begin
      mem[wr_ptr_reg] <= input_link.packet;
    end
  end

  a_count_bound : assert property (@(posedge clock) disable iff (!reset)
    count_reg <= COUNT_FULL)
    else $error("channel_input_buffer: count above DEPTH");

  a_no_enq_full : assert property (@(posedge clock) disable iff (!reset)
    !(enq && full))
    else $error("channel_input_buffer: enqueue while full");

  // Popping an empty buffer is harmless in hardware, so it only warns.
  a_no_deq_empty : assert property (@(posedge clock) disable iff (!reset)
    !(dequeue && empty))
    else $warning("channel_input_buffer: dequeue while empty ignored");

  a_req_stable : assert property (@(posedge clock) disable iff (!reset)
    $past(input_link.req && !input_link.ack) |-> input_link.req)
    else $error("channel_input_buffer: req dropped before ack");

endmodule

// File: tb/tb_channel_input_buffer.sv
// Directed bench for channel_input_buffer (DEPTH=4) with a queue-based
// reference model checked every cycle plus hand-computed spot checks.
module tb_channel_input_buffer;
  import channel_input_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                      clock;
  logic                      reset;
  logic                      dequeue;
  logic                      head_valid;
  logic [TIA_TAG_WIDTH-1:0]  head_tag;
  logic [TIA_WORD_WIDTH-1:0] head_data;
  logic [CW-1:0]             count;
  logic                      full;
  logic                      empty;

  link_if lnk ();

  channel_input_buffer #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .input_link (lnk),
    .dequeue    (dequeue),
    .head_valid (head_valid),
    .head_tag   (head_tag),
    .head_data  (head_data),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an unbounded queue limited to DEPTH by the ack rule.
  packet_t model_q[$];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      model_q.delete();
    end else begin
      automatic bit m_deq = dequeue && (model_q.size() > 0);
      automatic bit m_enq = lnk.req && (model_q.size() < DEPTH);
      automatic packet_t p = lnk.packet;
      if (m_deq) void'(model_q.pop_front());
      if (m_enq) model_q.push_back(p);
    end
  end

  always @(negedge clock) begin
    automatic int n = model_q.size();
    chk("count", 64'(count), 64'(n));
    chk("head_valid", 64'(head_valid), 64'(n > 0));
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("ack", 64'(lnk.ack), 64'(reset && (n < DEPTH)));
    if (n > 0) begin
      chk("head_data", 64'(head_data), 64'(model_q[0].data));
      chk("head_tag", 64'(head_tag), 64'(model_q[0].tag));
    end
  end

  // Apply inputs, let one rising edge happen, return 1 time unit after it.
  task automatic drive(input logic r, input logic [1:0] t, input logic [31:0] d, input logic dq);
    lnk.req         = r;
    lnk.packet.tag  = t;
    lnk.packet.data = d;
    dequeue         = dq;
    @(posedge clock);
    #1;
    $display("cyc req=%0b tag=%0d data=%02h deq=%0b -> count=%0d hv=%0b head=%02h ack=%0b",
             r, t, d, dq, count, head_valid, head_data, lnk.ack);
  endtask

  logic [31:0] exp_seq [10];

  initial begin
    reset           = 1'b0;
    lnk.req         = 1'b0;
    lnk.packet.tag  = '0;
    lnk.packet.data = '0;
    dequeue         = 1'b0;

    // Reset then idle
    #3;
    chk("rst_ack", 64'(lnk.ack), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_hv", 64'(head_valid), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #1 chk("rel_ack", 64'(lnk.ack), 64'd1);

    // Fill and stall
    for (int i = 0; i < 4; i++) drive(1'b1, 2'd1, 32'hA0 + 32'(i), 1'b0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_ack", 64'(lnk.ack), 64'd0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'd1, 32'hA4, 1'b0);
      chk("stall_head", 64'(head_data), 64'hA0);
    end

    // Drain; the held 5th request is taken once ack returns
    for (int i = 0; i < 5; i++) begin
      chk("drain_head", 64'(head_data), 64'hA0 + 64'(i));
      drive((i < 2) ? 1'b1 : 1'b0, 2'd1, 32'hA4, 1'b1);
      if (i == 0) chk("ack_after_pop", 64'(lnk.ack), 64'd1);
    end
    chk("drain_empty", 64'(empty), 64'd1);

    // Simultaneous push/pop at count=2
    drive(1'b1, 2'd2, 32'h0E, 1'b0);
    drive(1'b1, 2'd3, 32'h0F, 1'b0);
    exp_seq[0] = 32'h0E;
    exp_seq[1] = 32'h0F;
    for (int i = 0; i < 8; i++) exp_seq[i+2] = 32'h10 + 32'(i);
    for (int i = 0; i < 8; i++) begin
      chk("pp_head", 64'(head_data), 64'(exp_seq[i]));
      drive(1'b1, 2'(i), 32'h10 + 32'(i), 1'b1);
      chk("pp_count", 64'(count), 64'd2);
    end
    for (int i = 8; i < 10; i++) begin
      chk("pp_tail_head", 64'(head_data), 64'(exp_seq[i]));
      drive(1'b0, 2'd0, 32'h0, 1'b1);
    end
    chk("pp_empty", 64'(empty), 64'd1);

    // Dequeue on empty, then a single enqueue
    drive(1'b0, 2'd0, 32'h0, 1'b1);
    chk("deq_empty_count", 64'(count), 64'd0);
    drive(1'b1, 2'd1, 32'h55, 1'b0);
    chk("after_hv", 64'(head_valid), 64'd1);
    chk("after_data", 64'(head_data), 64'h55);
    drive(1'b0, 2'd0, 32'h0, 1'b1);

    // Async reset mid-operation with count=3 and req high
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd1, 32'h31 + 32'(i), 1'b0);
    chk("pre_rst_count", 64'(count), 64'd3);
    lnk.req         = 1'b1;
    lnk.packet.data = 32'h34;
    #3 reset = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_hv", 64'(head_valid), 64'd0);
    chk("async_ack", 64'(lnk.ack), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    drive(1'b1, 2'd1, 32'h34, 1'b0);
    chk("post_rst_hv", 64'(head_valid), 64'd1);
    chk("post_rst_data", 64'(head_data), 64'h34);
    chk("post_rst_count", 64'(count), 64'd1);
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
